sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares the single async 16-bit SRAM port between two requesters.
//  VGA scan-out issues one pixel read per cycle. The compute client (DLA random walker) issues reads and writes through a req/ack handshake.
//  Sits between VGA_Controller coordinates and the SRAM pins, in the VGA_CTL_CLK domain.
//  Owns every SRAM strobe, so no client drives the DQ tristate directly.
// PARAMETERS
//  ADDR_W        20   SRAM address width, {x[9:0], y[9:0]}
//  DATA_W        16   SRAM data width
//  STARVE_LIMIT  64   client wait cycles before one VGA slot is stolen (1..255)
// PORTS
//  iCLK          in   1       VGA_CTL_CLK; all logic on rising edge
//  iRST          in   1       async, active-high reset
//  iVGA_REQ      in   1       VGA wants a read this cycle (active display)
//  iVGA_ADDR     in   ADDR_W  {Coord_X, Coord_Y}
//  oVGA_DATA     out  DATA_W  pixel data, held between valids
//  oVGA_VALID    out  1       oVGA_DATA updated this cycle
//  oVGA_MISS     out  1       a VGA request was dropped (turnaround or steal)
//  iCLI_REQ      in   1       client request; held until oCLI_ACK
//  iCLI_WE       in   1       1 = write, 0 = read
//  iCLI_ADDR     in   ADDR_W  client address
//  iCLI_WDATA    in   DATA_W  client write data
//  oCLI_RDATA    out  DATA_W  read data; valid with oCLI_ACK for reads
//  oCLI_ACK      out  1       one-cycle completion pulse
//  oSRAM_ADDR    out  ADDR_W  registered address
//  oSRAM_WE_N    out  1       write strobe, active low
//  oSRAM_OE_N    out  1       output enable, active low
//  oSRAM_DQ_OE   out  1       1 = top level drives DQ with oSRAM_DQ_OUT
//  oSRAM_DQ_OUT  out  DATA_W  write data
//  iSRAM_DQ      in   DATA_W  DQ read back
// BEHAVIOUR
//  Reset values (asynchronous):
//   - WE_N=1, OE_N=1, DQ_OE=0.
//   - oSRAM_ADDR=0, oSRAM_DQ_OUT=0.
//   - All data outputs 0; VALID, MISS and ACK are 0.
//   - State IDLE; starve counter 0.
//  States:
//   - IDLE: no access; OE_N=1.
//   - VRD: VGA read; OE_N=0.
//   - CRD: client read; OE_N=0.
//   - CWR: client write; WE_N=0, DQ_OE=1.
//   - TURN: write recovery; WE_N=1, OE_N=1, DQ_OE=1 with data held.
//  Per-edge decision, in priority order:
//   1. State is CWR -> next state is TURN, unconditionally.
//   2. Client pending and starve==STARVE_LIMIT -> client op (CRD/CWR); a coincident VGA request is dropped.
//   3. iVGA_REQ -> VRD, latching iVGA_ADDR.
//   4. Client pending -> CRD or CWR per iCLI_WE, latching iCLI_ADDR/iCLI_WDATA.
//   5. Otherwise -> IDLE.
//  Client pending = iCLI_REQ && !(ACK this cycle).
//  Read latency: request sampled at edge t, address registered at t, iSRAM_DQ captured at t+1.
//   - VGA read: oVGA_VALID=1 during the cycle after t+1.
//   - Client read: oCLI_ACK=1 with oCLI_RDATA during the cycle after t+1.
//  Write: CWR lasts exactly 1 cycle, then TURN lasts 1 cycle; oCLI_ACK pulses during TURN.
//  A VGA request arriving while the next state is forced to TURN (rule 1) is dropped.
//  Every dropped VGA request pulses oVGA_MISS for 1 cycle; oVGA_DATA keeps its last value.
//  Client: at most one op in flight. Back-to-back ops: a new req seen the cycle after ACK is eligible.
//  Changing client inputs while pending is illegal; the bench flags it as an assertion.
//  Starve counter:
//   - Increments each cycle the client is pending and not granted; saturates at STARVE_LIMIT.
//   - Clears on client grant and when iCLI_REQ=0.
//  Reset asserted mid-write: WE_N rises immediately (async); the in-flight op is lost with no ACK.
//  The SRAM is never read and written in the same cycle. DQ_OE=1 only in CWR and TURN.
// STRUCTURE
//  Package sram_arb_pkg:
//   - state enum (IDLE, VRD, CRD, CWR, TURN)
//   - ADDR_W/DATA_W constants
//   - function pack_xy(x, y) -> {x, y}
//  Sub-module sram_starve_ctr: saturating counter, inputs pending/grant, output hit.
//  Everything else lives in one FSM plus output registers.
// TESTING
//  - Reset mid-CWR: assert iRST -> WE_N=1, DQ_OE=0 combinationally from reset; no ACK after release.
//  - VGA only: iVGA_REQ=1 for 8 cycles, SRAM preloaded with addr -> data.
//    Expect 8 VALID pulses, each 2 edges after its request, data matching, MISS never set.
//  - Client write then read of 0x0C8C8 (data 0xFFFF) with VGA idle.
//    Expect WE_N low for 1 cycle, ACK in TURN; read ACK 2 edges later with RDATA=0xFFFF.
//  - Write during active VGA with STARVE_LIMIT=4 and iVGA_REQ held high.
//    Expect the client granted exactly on the 5th waiting cycle; MISS pulses on the stolen slot and on the TURN slot.
//  - Simultaneous first cycle, iVGA_REQ=1 and iCLI_REQ=1 (read), starve=0.
//    Expect VGA granted first; starve counter increments; client ACK only after VGA deasserts or the limit is hit.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the VGA/client SRAM port arbiter.
package sram_arb_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned XY_W   = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VRD,
        ST_CRD,
        ST_CWR,
        ST_TURN
    } arb_state_e;

    // Client command payload; must stay stable while the request is pending.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cli_cmd_t;

    function automatic logic [ADDR_W-1:0] pack_xy(input logic [XY_W-1:0] x, input logic [XY_W-1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the arbiter, its two clients and the SRAM pins.
interface sram_port_arbiter_if;
    import sram_arb_pkg::*;

    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;
    logic              vga_valid;
    logic              vga_miss;

    logic              cli_req;
    cli_cmd_t          cli_cmd;
    logic [DATA_W-1:0] cli_rdata;
    logic              cli_ack;

    logic [ADDR_W-1:0] sram_addr;
    logic              sram_we_n;
    logic              sram_oe_n;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_out;
    logic [DATA_W-1:0] sram_dq;

    modport master (
        output vga_req, vga_addr, cli_req, cli_cmd, sram_dq,
        input  vga_data, vga_valid, vga_miss, cli_rdata, cli_ack,
        input  sram_addr, sram_we_n, sram_oe_n, sram_dq_oe, sram_dq_out
    );

    modport slave (
        input  vga_req, vga_addr, cli_req, cli_cmd, sram_dq,
        output vga_data, vga_valid, vga_miss, cli_rdata, cli_ack,
        output sram_addr, sram_we_n, sram_oe_n, sram_dq_oe, sram_dq_out
    );

endinterface

// File: rtl/sram_starve_ctr.sv
// Counts cycles a pending client is passed over; hit flags the limit.
module sram_starve_ctr #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic pending,
    input  logic grant,
    output logic hit
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] count;

    // Pending is false while an op is in flight, so clearing on !pending also covers iCLI_REQ=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            hit   <= 1'b0;
        end else if (grant || !pending) begin
            count <= '0;
            hit   <= 1'b0;
        end else if (!hit) begin
            count <= count + CNT_W'(1);
            hit   <= (count + CNT_W'(1)) == CNT_W'(LIMIT);
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one async SRAM port between VGA scan-out and a req/ack compute client.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic                iCLK,
    input  logic                iRST,
    sram_port_arbiter_if.slave  bus
);

    arb_state_e state;
    arb_state_e next_state;
    logic       cli_pend_c;
    logic       cli_grant_c;
    logic       vga_drop_c;
    logic       starve_hit;

    sram_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk     (iCLK),
        .rst     (iRST),
        .pending (cli_pend_c),
        .grant   (cli_grant_c),
        .hit     (starve_hit)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state <= ST_IDLE;
        else      state <= next_state;
    end

    // Next-state decision; an op already in flight is never re-issued.
    always_comb begin
        next_state  = ST_IDLE;
        cli_pend_c  = bus.cli_req && !bus.cli_ack && (state != ST_CRD) && (state != ST_CWR);
        if (state == ST_CWR)
            next_state = ST_TURN;
        else if (cli_pend_c && starve_hit)
            next_state = bus.cli_cmd.we ? ST_CWR : ST_CRD;
        else if (bus.vga_req)
            next_state = ST_VRD;
        else if (cli_pend_c)
            next_state = bus.cli_cmd.we ? ST_CWR : ST_CRD;
        cli_grant_c = (next_state == ST_CRD) || (next_state == ST_CWR);
        vga_drop_c  = bus.vga_req && (next_state != ST_VRD);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            bus.sram_addr   <= '0;
            bus.sram_we_n   <= 1'b1;
            bus.sram_oe_n   <= 1'b1;
            bus.sram_dq_oe  <= 1'b0;
            bus.sram_dq_out <= '0;
            bus.vga_data    <= '0;
            bus.vga_valid   <= 1'b0;
            bus.vga_miss    <= 1'b0;
            bus.cli_rdata   <= '0;
            bus.cli_ack     <= 1'b0;
        end else begin
            bus.sram_we_n  <= !(next_state == ST_CWR);
            bus.sram_oe_n  <= !((next_state == ST_VRD) || (next_state == ST_CRD));
            bus.sram_dq_oe <= (next_state == ST_CWR) || (next_state == ST_TURN);
            if (next_state == ST_VRD)
                bus.sram_addr <= bus.vga_addr;
            else if (cli_grant_c)
                bus.sram_addr <= bus.cli_cmd.addr;
            if (next_state == ST_CWR)
                bus.sram_dq_out <= bus.cli_cmd.wdata;

            // Read data is captured one edge after the address was registered.
            bus.vga_valid <= (state == ST_VRD);
            if (state == ST_VRD)
                bus.vga_data <= bus.sram_dq;
            bus.cli_ack <= (state == ST_CRD) || (state == ST_CWR);
            if (state == ST_CRD)
                bus.cli_rdata <= bus.sram_dq;
            bus.vga_miss <= vga_drop_c;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural async SRAM.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    logic iCLK;
    logic iRST;
    int   vectors;
    int   miscompares;
    bit   pend_q;
    cli_cmd_t cli_snap;
    int   valid_cnt;

    logic [15:0] mem [1024];

    sram_port_arbiter_if bus ();

    sram_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Preload on reset so each read location has a known value A000+index.
    always @(posedge iCLK) begin
        if (iRST) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 16'hA000 + 16'(k);
        end else if (!bus.sram_we_n) begin
            mem[bus.sram_addr[9:0]] <= bus.sram_dq_out;
        end
    end
    assign bus.sram_dq = bus.sram_oe_n ? 16'hDEAD : mem[bus.sram_addr[9:0]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; client inputs must not change while a request is pending.
    task automatic step();
        logic     pend_now;
        cli_cmd_t snap_now;
        if (pend_q && bus.cli_req)
            check("cli_stable", 64'(bus.cli_cmd), 64'(cli_snap));
        pend_now = bus.cli_req && !bus.cli_ack && !iRST;
        snap_now = bus.cli_cmd;
        @(posedge iCLK);
        #1;
        pend_q   = pend_now;
        cli_snap = snap_now;
    endtask

    task automatic set_cli(input logic req, input logic we, input logic [19:0] addr, input logic [15:0] wdata);
        bus.cli_req       = req;
        bus.cli_cmd.we    = we;
        bus.cli_cmd.addr  = addr;
        bus.cli_cmd.wdata = wdata;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        valid_cnt   = 0;
        iRST        = 1'b1;
        bus.vga_req  = 1'b0;
        bus.vga_addr = '0;
        set_cli(1'b0, 1'b0, 20'h0, 16'h0);

        // Reset state
        step();
        step();
        check("rst_we_n",   bus.sram_we_n, 1);
        check("rst_oe_n",   bus.sram_oe_n, 1);
        check("rst_dq_oe",  bus.sram_dq_oe, 0);
        check("rst_addr",   bus.sram_addr, 0);
        check("rst_dq_out", bus.sram_dq_out, 0);
        check("rst_vdata",  bus.vga_data, 0);
        check("rst_valid",  bus.vga_valid, 0);
        check("rst_miss",   bus.vga_miss, 0);
        check("rst_rdata",  bus.cli_rdata, 0);
        check("rst_ack",    bus.cli_ack, 0);
        iRST = 1'b0;

        // VGA only: 8 back-to-back pixel reads
        for (int c = 0; c < 11; c++) begin
            bus.vga_req  = (c < 8);
            bus.vga_addr = pack_xy(10'(c), 10'(16 + c));
            step();
            check("vga_valid", bus.vga_valid, 64'(c >= 1 && c <= 8));
            check("vga_miss",  bus.vga_miss, 0);
            if (bus.vga_valid) valid_cnt++;
            if (c >= 1 && c <= 8)
                check("vga_data", bus.vga_data, 64'(16'hA010 + 16'(c - 1)));
        end
        check("vga_valid_cnt", 64'(valid_cnt), 8);

        // Client write then read of 0x0C8C8 with VGA idle
        set_cli(1'b1, 1'b1, 20'h0C8C8, 16'hFFFF);
        step();
        check("cwr_we_n",   bus.sram_we_n, 0);
        check("cwr_oe_n",   bus.sram_oe_n, 1);
        check("cwr_dq_oe",  bus.sram_dq_oe, 1);
        check("cwr_dq_out", bus.sram_dq_out, 16'hFFFF);
        check("cwr_addr",   bus.sram_addr, 20'h0C8C8);
        check("cwr_ack",    bus.cli_ack, 0);
        step();
        check("turn_we_n",  bus.sram_we_n, 1);
        check("turn_oe_n",  bus.sram_oe_n, 1);
        check("turn_dq_oe", bus.sram_dq_oe, 1);
        check("turn_ack",   bus.cli_ack, 1);
        bus.cli_req = 1'b0;
        step();
        check("wpost_ack",   bus.cli_ack, 0);
        check("wpost_dq_oe", bus.sram_dq_oe, 0);
        set_cli(1'b1, 1'b0, 20'h0C8C8, 16'h0000);
        step();
        check("crd_oe_n", bus.sram_oe_n, 0);
        check("crd_we_n", bus.sram_we_n, 1);
        check("crd_ack",  bus.cli_ack, 0);
        step();
        check("crd_ack2", bus.cli_ack, 1);
        check("crd_data", bus.cli_rdata, 16'hFFFF);
        bus.cli_req = 1'b0;
        step();
        check("rpost_ack", bus.cli_ack, 0);

        // Write during active VGA, STARVE_LIMIT=4: steal on the 5th waiting edge
        bus.vga_req  = 1'b1;
        bus.vga_addr = pack_xy(10'd0, 10'd5);
        set_cli(1'b1, 1'b1, 20'h00020, 16'h1234);
        for (int e = 1; e <= 4; e++) begin
            step();
            check("stv_oe_n", bus.sram_oe_n, 0);
            check("stv_we_n", bus.sram_we_n, 1);
            check("stv_miss", bus.vga_miss, 0);
        end
        step();
        check("steal_we_n",   bus.sram_we_n, 0);
        check("steal_dq_out", bus.sram_dq_out, 16'h1234);
        check("steal_addr",   bus.sram_addr, 20'h00020);
        check("steal_miss",   bus.vga_miss, 1);
        check("steal_valid",  bus.vga_valid, 1);
        check("steal_vdata",  bus.vga_data, 16'hA005);
        step();
        check("sturn_miss",  bus.vga_miss, 1);
        check("sturn_ack",   bus.cli_ack, 1);
        check("sturn_valid", bus.vga_valid, 0);
        check("sturn_oe_n",  bus.sram_oe_n, 1);
        check("sturn_vdata", bus.vga_data, 16'hA005);
        bus.cli_req = 1'b0;
        step();
        check("sres_miss", bus.vga_miss, 0);
        check("sres_ack",  bus.cli_ack, 0);
        check("sres_oe_n", bus.sram_oe_n, 0);
        check("sres_addr", bus.sram_addr, 20'h00005);
        bus.vga_req = 1'b0;
        step();
        check("sres_valid", bus.vga_valid, 1);

        // Simultaneous first cycle: VGA wins, client read follows VGA release
        bus.vga_req  = 1'b1;
        bus.vga_addr = pack_xy(10'd1, 10'd7);
        set_cli(1'b1, 1'b0, 20'h00030, 16'h0000);
        step();
        check("sim_addr1",  bus.sram_addr, 20'h00407);
        check("sim_starve1", 64'(dut.u_starve.count), 1);
        check("sim_ack1",   bus.cli_ack, 0);
        step();
        check("sim_starve2", 64'(dut.u_starve.count), 2);
        check("sim_valid2", bus.vga_valid, 1);
        check("sim_vdata2", bus.vga_data, 16'hA007);
        bus.vga_req = 1'b0;
        step();
        check("sim_addr3", bus.sram_addr, 20'h00030);
        check("sim_ack3",  bus.cli_ack, 0);
        check("sim_miss3", bus.vga_miss, 0);
        step();
        check("sim_ack4",   bus.cli_ack, 1);
        check("sim_rdata4", bus.cli_rdata, 16'hA030);
        bus.cli_req = 1'b0;
        step();
        check("sim_ack5", bus.cli_ack, 0);

        // Reset asserted mid-CWR
        set_cli(1'b1, 1'b1, 20'h00040, 16'h5555);
        step();
        check("mid_we_n", bus.sram_we_n, 0);
        #2;
        iRST        = 1'b1;
        bus.cli_req = 1'b0;
        #1;
        check("arst_we_n",  bus.sram_we_n, 1);
        check("arst_dq_oe", bus.sram_dq_oe, 0);
        check("arst_oe_n",  bus.sram_oe_n, 1);
        step();
        iRST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("arst_ack", bus.cli_ack, 0);
            check("arst_we_idle", bus.sram_we_n, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
